lsu_mem_port: RTL and testbench

- Data-memory port unit: consumes the controller's mem_read/mem_write/mem_ctrl and the ALU address and executes the access on a word-wide memory bus.
- Uses a req/ready handshake with byte-lane steering, store-data replication, and load sign/zero extension.
- Drives a stall to the pipeline while an access is outstanding.
- Flags misaligned addresses, illegal opcode/mem_ctrl combinations, and bus timeouts.

---
 rtl/mem_pkg.sv | 17 +
 rtl/load_extend.sv | 17 +
 rtl/lsu_mem_port.sv | 94 +++++++++
 tb/tb_lsu_mem_port.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings, FSM states and access-size helper for the LSU memory port.
package mem_pkg;
  localparam logic [2:0] MEM_LB  = 3'b000;
  localparam logic [2:0] MEM_LH  = 3'b001;
  localparam logic [2:0] MEM_LW  = 3'b010;
  localparam logic [2:0] MEM_LBU = 3'b011;
  localparam logic [2:0] MEM_LHU = 3'b100;
  localparam logic [2:0] MEM_SB  = 3'b101;
  localparam logic [2:0] MEM_SH  = 3'b110;
  localparam logic [2:0] MEM_SW  = 3'b111;
  typedef enum logic [1:0] {IDLE, REQ, RESP} lsu_state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} mem_size_t;
  function automatic mem_size_t mem_size(input logic [2:0] ctrl);
    return (ctrl == MEM_LW || ctrl == MEM_SW) ? SZ_W :
           (ctrl == MEM_LH || ctrl == MEM_LHU || ctrl == MEM_SH) ? SZ_H : SZ_B;
  endfunction
endpackage

// File: rtl/load_extend.sv
// load_extend: shifts the addressed bytes of a bus word down and sign/zero-extends them.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_ctrl,
  output logic [31:0] o_data
);
  logic [31:0] w_sh;
  assign w_sh = i_word >> {i_off, 3'b000};
  always_comb
    o_data = (i_ctrl == MEM_LB)  ? {{24{w_sh[7]}}, w_sh[7:0]} :
             (i_ctrl == MEM_LBU) ? {24'd0, w_sh[7:0]} :
             (i_ctrl == MEM_LH)  ? {{16{w_sh[15]}}, w_sh[15:0]} :
             (i_ctrl == MEM_LHU) ? {16'd0, w_sh[15:0]} : w_sh;
endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: executes controller loads/stores on a word-wide req/ready bus,
// stalling the pipeline while an access is outstanding.
module lsu_mem_port
  import mem_pkg::*;
#(
  parameter int WAIT_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  mem_ctrl,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);
  lsu_state_t  r_state, w_next;
  logic [7:0]  r_cnt;
  logic [2:0]  r_ctrl;
  logic [1:0]  r_off;
  logic        r_err;
  logic        w_idle, w_cmd, w_illegal, w_mis, w_accept, w_timeout;
  mem_size_t   w_size;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_ext;
  assign w_idle    = r_state == IDLE;
  assign w_cmd     = mem_read | mem_write;
  assign w_size    = mem_size(mem_ctrl);
  assign w_illegal = w_idle & ((mem_read & mem_write) | (mem_read & (mem_ctrl >= MEM_SB)) |
                               (mem_write & (mem_ctrl <= MEM_LHU)));
  assign w_mis     = w_idle & w_cmd & !w_illegal &
                     (((w_size == SZ_H) & addr[0]) | ((w_size == SZ_W) & (|addr[1:0])));
  assign w_accept  = w_idle & w_cmd & !w_illegal & !w_mis;
  assign w_timeout = (r_state == REQ) & !bus_ready & (r_cnt == 8'(WAIT_MAX - 1));
  assign w_be      = (w_size == SZ_B) ? 4'b0001 << addr[1:0] :
                     (w_size == SZ_H) ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign w_wdata   = !mem_write       ? 32'd0 :
                     (w_size == SZ_B) ? {4{wdata[7:0]}} :
                     (w_size == SZ_H) ? {2{wdata[15:0]}} : wdata;
  assign bus_req   = r_state == REQ;
  assign busy      = w_accept | bus_req;
  assign done      = (r_state == RESP) & !r_err;
  assign bus_err   = w_illegal | ((r_state == RESP) & r_err);
  assign misalign  = w_mis;
  load_extend u_ext (
    .i_word (bus_rdata),
    .i_off  (r_off),
    .i_ctrl (r_ctrl),
    .o_data (w_ext)
  );
  always_comb
    w_next = w_idle ? (w_accept ? REQ : IDLE) :
             (r_state == REQ) ? ((bus_ready | w_timeout) ? RESP : REQ) : IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_ctrl    <= '0;
      r_off     <= '0;
      r_err     <= 1'b0;
      rdata     <= '0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt     <= '0;
        r_ctrl    <= mem_ctrl;
        r_off     <= addr[1:0];
        bus_we    <= mem_write;
        bus_addr  <= {addr[31:2], 2'b00};
        bus_be    <= w_be;
        bus_wdata <= w_wdata;
      end
      if (r_state == REQ) begin
        r_cnt <= r_cnt + 8'd1;
        r_err <= !bus_ready;
        if (bus_ready & !bus_we) rdata <= w_ext;
      end
    end
endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: directed vector table, reset-abort sequence and randomized
// accesses checked against a byte-level behavioural model.
module tb_lsu_mem_port;
  localparam int WM = 4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  mem_ctrl = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic        busy, done, misalign, bus_err, bus_req, bus_we;
  logic [3:0]  bus_be;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = '0;
  int checks = 0, errors = 0;
  logic [31:0] model_rd = '0;

  always #5 clk = ~clk;

  lsu_mem_port #(.WAIT_MAX(WM)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_ctrl(mem_ctrl), .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy),
    .done(done), .misalign(misalign), .bus_err(bus_err), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  // kind: 0 ok, 1 misaligned, 2 illegal, 3 timeout, 4 no command
  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] brd;
    int          dly;
    int          kind;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          nreq;
  } vec_t;

  task automatic chk(input string nm, input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s got %h expected %h", nm, what, act, exp);
    end
  endtask

  function automatic vec_t model(input vec_t c, input logic [31:0] prev);
    vec_t e;
    int sz, off;
    logic ill;
    logic [63:0] v, mask;
    e = c;
    ill = (c.rd && c.wr) || (c.rd && c.ctrl >= 5) || (c.wr && c.ctrl <= 4);
    sz = (c.ctrl == 2 || c.ctrl == 7) ? 4 : (c.ctrl == 1 || c.ctrl == 4 || c.ctrl == 6) ? 2 : 1;
    off = int'(c.addr[1:0]);
    e.be = '0; e.wd = '0; e.rdata = prev; e.nreq = 0;
    if (!(c.rd || c.wr)) e.kind = 4;
    else if (ill) e.kind = 2;
    else if (off % sz != 0) e.kind = 1;
    else begin
      e.kind = (c.dly >= WM) ? 3 : 0;
      e.nreq = (c.dly >= WM) ? WM : c.dly + 1;
      for (int i = 0; i < 4; i++) begin
        e.be[i] = (i >= off) && (i < off + sz);
        if (c.wr) e.wd[8*i +: 8] = c.wdata[8*(i % sz) +: 8];
      end
      if (c.rd && e.kind == 0) begin
        mask = (64'd1 << (8*sz)) - 64'd1;
        v = ({32'd0, c.brd} >> (8*off)) & mask;
        if ((c.ctrl == 0 || c.ctrl == 1) && v[8*sz-1]) v = v | ~mask;
        e.rdata = v[31:0];
      end
    end
    return e;
  endfunction

  task automatic verify(input string nm, input vec_t v);
    int nreq, ndone, nerr;
    logic b0, m0, e0, busy_late, unstable, a_we;
    logic [31:0] a_addr, a_wd;
    logic [3:0] a_be;
    @(negedge clk);
    mem_read = v.rd; mem_write = v.wr; mem_ctrl = v.ctrl; addr = v.addr; wdata = v.wdata;
    #1;
    b0 = busy; m0 = misalign; e0 = bus_err;
    nreq = 0; ndone = 0; nerr = 0; busy_late = 0; unstable = 0;
    a_addr = '0; a_wd = '0; a_be = '0; a_we = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      mem_read = 0; mem_write = 0;
      #1;
      if (bus_req) begin
        if (nreq == 0) begin
          a_addr = bus_addr; a_be = bus_be; a_we = bus_we; a_wd = bus_wdata;
        end else if ({a_addr, a_be, a_we, a_wd} !== {bus_addr, bus_be, bus_we, bus_wdata}) unstable = 1;
        nreq++;
        bus_ready = (nreq == v.dly + 1);
        bus_rdata = v.brd;
      end else begin
        bus_ready = 1'($urandom);
        bus_rdata = $urandom;
        ndone += int'(done);
        nerr += int'(bus_err);
        if (busy) busy_late = 1;
      end
    end
    bus_ready = 0;
    chk(nm, "busy_at_accept", 32'(b0), 32'(v.kind == 0 || v.kind == 3));
    chk(nm, "misalign", 32'(m0), 32'(v.kind == 1));
    chk(nm, "illegal_err", 32'(e0), 32'(v.kind == 2));
    chk(nm, "req_cycles", 32'(nreq), 32'(v.nreq));
    chk(nm, "done_pulses", 32'(ndone), 32'(v.kind == 0));
    chk(nm, "timeout_err", 32'(nerr), 32'(v.kind == 3));
    chk(nm, "busy_idle", 32'(busy_late), 32'd0);
    if (v.nreq > 0) begin
      chk(nm, "bus_addr", a_addr, {v.addr[31:2], 2'b00});
      chk(nm, "bus_be", 32'(a_be), 32'(v.be));
      chk(nm, "bus_we", 32'(a_we), 32'(v.wr));
      chk(nm, "bus_wdata", a_wd, v.wd);
      chk(nm, "bus_stable", 32'(unstable), 32'd0);
    end
    chk(nm, "rdata", rdata, v.rdata);
    model_rd = v.rdata;
  endtask

  vec_t tbl[14];
  vec_t rv;

  initial begin
    tbl[0]  = '{0, 1, 3'd7, 32'h100, 32'hDEADBEEF, 32'h0,        1, 0, 4'hF, 32'hDEADBEEF, 32'h00000000, 2};
    tbl[1]  = '{0, 1, 3'd5, 32'h103, 32'h000000A5, 32'h0,        0, 0, 4'h8, 32'hA5A5A5A5, 32'h00000000, 1};
    tbl[2]  = '{0, 1, 3'd6, 32'h102, 32'h00001234, 32'h0,        2, 0, 4'hC, 32'h12341234, 32'h00000000, 3};
    tbl[3]  = '{1, 0, 3'd0, 32'h101, 32'h0,        32'h123480FF, 0, 0, 4'h2, 32'h0,        32'hFFFFFF80, 1};
    tbl[4]  = '{1, 0, 3'd3, 32'h101, 32'h0,        32'h123480FF, 0, 0, 4'h2, 32'h0,        32'h00000080, 1};
    tbl[5]  = '{1, 0, 3'd1, 32'h102, 32'h0,        32'h80010000, 1, 0, 4'hC, 32'h0,        32'hFFFF8001, 2};
    tbl[6]  = '{1, 0, 3'd4, 32'h102, 32'h0,        32'h80010000, 0, 0, 4'hC, 32'h0,        32'h00008001, 1};
    tbl[7]  = '{1, 0, 3'd2, 32'h106, 32'h0,        32'h11111111, 0, 1, 4'h0, 32'h0,        32'h00008001, 0};
    tbl[8]  = '{1, 0, 3'd6, 32'h100, 32'h0,        32'h22222222, 0, 2, 4'h0, 32'h0,        32'h00008001, 0};
    tbl[9]  = '{1, 0, 3'd2, 32'h200, 32'h0,        32'hCAFEF00D, 3, 0, 4'hF, 32'h0,        32'hCAFEF00D, 4};
    tbl[10] = '{1, 0, 3'd2, 32'h204, 32'h0,        32'h33333333, 9, 3, 4'hF, 32'h0,        32'hCAFEF00D, 4};
    tbl[11] = '{1, 1, 3'd2, 32'h208, 32'h5,        32'h44444444, 0, 2, 4'h0, 32'h0,        32'hCAFEF00D, 0};
    tbl[12] = '{0, 1, 3'd7, 32'h102, 32'h6,        32'h0,        0, 1, 4'h0, 32'h0,        32'hCAFEF00D, 0};
    tbl[13] = '{0, 1, 3'd6, 32'h101, 32'h7,        32'h0,        0, 1, 4'h0, 32'h0,        32'hCAFEF00D, 0};
    repeat (2) @(negedge clk);
    chk("reset", "rdata", rdata, 32'd0);
    chk("reset", "bus_addr", bus_addr, 32'd0);
    chk("reset", "bus_be", 32'(bus_be), 32'd0);
    chk("reset", "bus_wdata", bus_wdata, 32'd0);
    chk("reset", "ctl", 32'({bus_req, bus_we, busy, done, misalign, bus_err}), 32'd0);
    rst_n = 1;
    for (int i = 0; i < 14; i++) verify($sformatf("vec%0d", i), tbl[i]);
    @(negedge clk);
    mem_read = 1; mem_ctrl = 3'd2; addr = 32'h300;
    @(negedge clk);
    mem_read = 0; bus_ready = 0;
    #1 chk("rst_mid", "bus_req_before", 32'(bus_req), 32'd1);
    #2 rst_n = 0;
    #1;
    chk("rst_mid", "bus_req", 32'(bus_req), 32'd0);
    chk("rst_mid", "busy", 32'(busy), 32'd0);
    chk("rst_mid", "rdata", rdata, 32'd0);
    chk("rst_mid", "bus_addr", bus_addr, 32'd0);
    @(negedge clk);
    rst_n = 1;
    verify("after_rst", '{1, 0, 3'd2, 32'h200, 32'h0, 32'h600DF00D, 0, 0, 4'hF, 32'h0, 32'h600DF00D, 1});
    for (int n = 0; n < 200; n++) begin
      int sel;
      sel = $urandom_range(0, 9);
      rv.rd = (sel <= 3) || (sel == 8);
      rv.wr = (sel >= 4 && sel <= 8);
      rv.ctrl = rv.rd && !rv.wr ? 3'($urandom_range(0, 5)) : rv.wr && !rv.rd ? 3'($urandom_range(4, 7)) : 3'($urandom);
      rv.addr = $urandom;
      if ($urandom_range(0, 1) == 0) rv.addr[1:0] = 2'b00;
      rv.wdata = $urandom;
      rv.brd = $urandom;
      rv.dly = $urandom_range(0, 5);
      verify($sformatf("rand%0d", n), model(rv, model_rd));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
